// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchroniser, baud down-counter FSM, and a small
// FIFO drained through a valid/ready handshake. Errors are one-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned SYSTEM_CLK = 25_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned DEPTH      = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned CPS   = SYSTEM_CLK / BAUDRATE;
  localparam int unsigned CNT_W = $clog2(CPS);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CPS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CPS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             s1_q, s1_d, s2_q, s2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             frame_error_q, frame_error_d;
  logic             overrun_q, overrun_d;

  logic tick, push, pop, push_ok;

  assign rx_valid    = (count_q != '0);
  assign rx_data     = mem_q[rptr_q];
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

  always_comb begin
    s1_d          = rx_in;
    s2_d          = s1_q;
    state_d       = state_q;
    cnt_d         = cnt_q - CNT_ONE;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_error_d = 1'b0;
    tick          = (cnt_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (!s2_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (!s2_q) begin
            state_d   = S_DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[bit_idx_q] = s2_q;
          cnt_d              = CNT_FULL;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s2_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low produces a single frame error, not one per frame time.
        if (s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = rx_valid && rx_ready;
    push_ok   = push && ((count_q != COUNT_MAX) || pop);
    overrun_d = push && !push_ok;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;

    if (push_ok) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + PTR_ONE;
    end
    if (pop) rptr_d = rptr_q + PTR_ONE;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      mem_q         <= '{default: '0};
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
8N1 UART receiver for the kianv SoC peripheral bus. It is the receive-side counterpart to the SoC's UART transmitter. It oversamples the asynchronous rx line with a baud down-counter and assembles bytes LSB-first. Received bytes are buffered in a small FIFO drained by the CPU through a valid/ready handshake. Frame errors and overruns are flagged as single-cycle pulses.

Parameters:
SYSTEM_CLK, 25_000_000, core clock frequency in Hz.
BAUDRATE, 115200, line rate in baud; CPS = SYSTEM_CLK/BAUDRATE (integer division), CPS >= 4 required.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  core clock, all logic on posedge.
resetn  in  1  asynchronous active-low reset.
rx_in  in  1  serial line, asynchronous to clk, idle high.
rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer pops the head when rx_valid&&rx_ready.
frame_error  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: completed byte dropped, FIFO full.

Behaviour:
- Reset: one clock, asynchronous active-low resetn. Assertion immediately clears FSM to IDLE, counters, FIFO pointers and count, and sync flops. Reset values: sync flops=1, rx_valid=0, rx_data=0, frame_error=0, overrun=0. Reset mid-frame discards the partial byte.
- Synchroniser: rx_in passes through two flops (s1, s2). The FSM sees only s2.
- Baud counter cnt: counts down each cycle. "Tick" means cnt==0 in a cycle; on a tick, cnt reloads per the state transition.
- FSM states and transitions:
  - IDLE: if s2==0, go to START with cnt=CPS/2-1.
  - START: on tick, if s2==0 go to DATA with cnt=CPS-1 and bit index 0; else false start, back to IDLE.
  - DATA: on tick, shift s2 into bit[index] (LSB first) and reload cnt=CPS-1. After index 7, go to STOP.
  - STOP: on tick, if s2==1, push the byte and go to IDLE. If s2==0, pulse frame_error, discard the byte, and go to BREAK.
  - BREAK: stay until s2==1, then go to IDLE. A held-low line yields exactly one frame_error.
- FIFO: DEPTH entries, read/write pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
  - rx_data is the head entry; it is combinational from storage.
  - Pop happens when rx_valid&&rx_ready.
  - Push on stop acceptance succeeds if count<DEPTH after accounting for a pop in the same cycle. A simultaneous pop and push while full is accepted; count stays DEPTH and there is no overrun.
  - Push while full with no pop drops the new byte, keeps FIFO contents, and pulses overrun for one cycle.
  - Pop while empty is ignored.
  - Simultaneous push and pop with count 1..DEPTH-1 leaves count unchanged.
- frame_error and overrun are registered and high for exactly one cycle per event.
- Latency, counting the first posedge at which rx_in is low as edge 1:
  - FSM enters START at edge 3.
  - The start bit is checked at edge 3+CPS/2.
  - Data bit k is sampled at edge 3+CPS/2+(k+1)*CPS.
  - The stop bit is sampled at edge 3+CPS/2+9*CPS.
  - rx_valid is high in the cycle after that edge.

Test Plan:
- Bench uses SYSTEM_CLK=16, BAUDRATE=1 (CPS=16). Send 0xA5 at ideal 16-cycle bit timing -> rx_valid rises after edge 155, rx_data=0xA5, no error pulses. Pop with rx_ready=1 -> rx_valid=0 next cycle.
- Glitch: rx_in low for 4 cycles then high -> START rejects at edge 11, FSM back in IDLE, rx_valid stays 0, no pulses.
- Send 0x3C with stop bit driven 0, then hold the line low for 100 cycles -> exactly one frame_error pulse, FIFO empty. Line returns high and 0x55 is sent -> 0x55 received.
- rx_ready=0; send 5 bytes 0x01..0x05 with DEPTH=4 -> overrun pulses once on byte 5. Popping yields 0x01,0x02,0x03,0x04 in order, then rx_valid=0.
- FIFO full with 4 bytes; hold rx_ready=1 so a pop coincides with the stop-bit push of byte 0x77 -> no overrun, count stays 4, 0x77 is popped last.
- Assert resetn=0 asynchronously mid data bit 3 of a frame -> outputs are immediately at reset values. Release resetn and send a fresh 0xC3 -> 0xC3 received, no frame_error.
